line_window_ctrl: RTL and testbench

//  Sequencer for a BUFFER_WIDTH-line pixel buffer built from per-line RAM banks.

---
 rtl/line_window_ctrl_if.sv | 30 +++
 rtl/line_window_ctrl.sv | 134 +++++++++++++
 tb/tb_line_window_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/line_window_ctrl_if.sv
// Pixel-stream control and line-buffer addressing bundle
// for the sliding-window line sequencer.
interface line_window_ctrl_if;
   logic        i_frame_start;
   logic        i_pix_valid;
   logic        i_bypass;
   logic        o_wr_en;
   logic [2:0]  o_wr_bank;
   logic [2:0]  o_top_bank;
   logic [10:0] o_addr;
   logic        o_win_valid;
   logic [10:0] o_ctr_x;
   logic [9:0]  o_ctr_y;
   logic        o_bypass;
   logic        o_frame_done;

   modport master (
      output i_frame_start, i_pix_valid, i_bypass,
      input  o_wr_en, o_wr_bank, o_top_bank, o_addr,
      input  o_win_valid, o_ctr_x, o_ctr_y,
      input  o_bypass, o_frame_done
   );

   modport slave (
      input  i_frame_start, i_pix_valid, i_bypass,
      output o_wr_en, o_wr_bank, o_top_bank, o_addr,
      output o_win_valid, o_ctr_x, o_ctr_y,
      output o_bypass, o_frame_done
   );
endinterface

// File: rtl/line_window_ctrl.sv
// Line-buffer sequencer: cursor tracking, bank rotation
// and window-complete flag with centre coordinates.
module line_window_ctrl #(
   parameter int H_LIMIT      = 800,
   parameter int V_LIMIT      = 525,
   parameter int BUFFER_WIDTH = 5
) (
   input logic              i_clk,
   input logic              i_rst_n,
   line_window_ctrl_if.slave bus
);

   localparam logic [10:0] HL1  = 11'(H_LIMIT - 1);
   localparam logic [9:0]  VL1  = 10'(V_LIMIT - 1);
   localparam logic [2:0]  BWB  = 3'(BUFFER_WIDTH - 1);
   localparam logic [10:0] BWX  = 11'(BUFFER_WIDTH - 1);
   localparam logic [9:0]  BWY  = 10'(BUFFER_WIDTH - 1);
   localparam logic [10:0] HX   = 11'(BUFFER_WIDTH / 2);
   localparam logic [9:0]  HY   = 10'(BUFFER_WIDTH / 2);

   typedef enum logic [1:0] {
      S_IDLE, S_FILL, S_RUN, S_DONE
   } state_t;

   state_t      state_q;
   logic [10:0] col_q, col_d;
   logic [9:0]  row_q, row_d;
   logic [2:0]  bank_q, bank_d;
   logic        eol, last, win_hit;

   logic        wr_en_q, win_q, done_q, byp_q;
   logic [2:0]  wr_bank_q;
   logic [10:0] addr_q, ctr_x_q;
   logic [9:0]  ctr_y_q;

   // Next cursor position after accepting one pixel
   always_comb begin
      col_d   = col_q + 11'd1;
      row_d   = row_q;
      bank_d  = bank_q;
      eol     = (col_q == HL1);
      last    = eol && (row_q == VL1);
      win_hit = (row_q >= BWY) && (col_q >= BWX);
      if (eol) begin
         col_d  = '0;
         row_d  = row_q + 10'd1;
         bank_d = (bank_q == BWB) ? '0 : bank_q + 3'd1;
      end
   end

   // Frame FSM, cursors and registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         col_q     <= '0;
         row_q     <= '0;
         bank_q    <= '0;
         wr_en_q   <= 1'b0;
         win_q     <= 1'b0;
         done_q    <= 1'b0;
         byp_q     <= 1'b0;
         wr_bank_q <= '0;
         addr_q    <= '0;
         ctr_x_q   <= '0;
         ctr_y_q   <= '0;
      end else begin
         wr_en_q <= 1'b0;
         win_q   <= 1'b0;
         done_q  <= 1'b0;
         if (bus.i_frame_start) begin
            state_q <= S_FILL;
            byp_q   <= bus.i_bypass;
            col_q   <= '0;
            row_q   <= '0;
            bank_q  <= '0;
            if (bus.i_pix_valid) begin
               wr_en_q   <= 1'b1;
               addr_q    <= '0;
               wr_bank_q <= '0;
               col_q     <= 11'd1;
               if (bus.i_bypass) begin
                  win_q   <= 1'b1;
                  ctr_x_q <= '0;
                  ctr_y_q <= '0;
               end
            end
         end else begin
            unique case (state_q)
               S_IDLE: state_q <= S_IDLE;
               S_FILL, S_RUN: begin
                  if (bus.i_pix_valid) begin
                     wr_en_q   <= 1'b1;
                     addr_q    <= col_q;
                     wr_bank_q <= bank_q;
                     if (byp_q) begin
                        win_q   <= 1'b1;
                        ctr_x_q <= col_q;
                        ctr_y_q <= row_q;
                     end else if (win_hit) begin
                        win_q   <= 1'b1;
                        ctr_x_q <= col_q - HX;
                        ctr_y_q <= row_q - HY;
                     end
                     col_q  <= col_d;
                     row_q  <= row_d;
                     bank_q <= bank_d;
                     if (last)
                        state_q <= S_DONE;
                     else if (eol && state_q == S_FILL
                              && row_d == BWY)
                        state_q <= S_RUN;
                  end
               end
               S_DONE: begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.o_wr_en      = wr_en_q;
   assign bus.o_wr_bank    = wr_bank_q;
   assign bus.o_top_bank   = (wr_bank_q == BWB) ? '0
                                                : wr_bank_q + 3'd1;
   assign bus.o_addr       = addr_q;
   assign bus.o_win_valid  = win_q;
   assign bus.o_ctr_x      = ctr_x_q;
   assign bus.o_ctr_y      = ctr_y_q;
   assign bus.o_bypass     = byp_q;
   assign bus.o_frame_done = done_q;

endmodule

// File: tb/tb_line_window_ctrl.sv
// Self-checking bench for line_window_ctrl: table vectors,
// directed frame sequences and a pixel-index reference model.
module tb_line_window_ctrl;

   localparam int H    = 8;
   localparam int V    = 6;
   localparam int BW   = 5;
   localparam int HALF = BW / 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   line_window_ctrl_if bus ();

   line_window_ctrl #(
      .H_LIMIT(H), .V_LIMIT(V), .BUFFER_WIDTH(BW)
   ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   bit m_act, m_pend, m_byp;
   int m_n;
   int e_wr, e_win, e_done, e_addr, e_bank, e_cx, e_cy;

   // observations
   int cyc, wcnt, fx, fy, lx, ly, last_wr, done_cyc, dcnt, ridx;
   int banks[6];

   typedef struct {
      bit fs, pv, byp;
      int wr, addr, bank, win, bypass;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_act = 0; m_pend = 0; m_byp = 0; m_n = 0;
      e_wr = 0; e_win = 0; e_done = 0;
      e_addr = 0; e_bank = 0; e_cx = 0; e_cy = 0;
   endtask

   task automatic model(bit fs, bit pv, bit byp);
      int c, r;
      e_wr = 0; e_win = 0; e_done = 0;
      if (fs) begin
         m_act = 1; m_n = 0; m_byp = byp; m_pend = 0;
      end else if (m_pend) begin
         e_done = 1; m_pend = 0;
      end
      if (m_act && pv) begin
         c = m_n % H;
         r = m_n / H;
         e_wr = 1; e_addr = c; e_bank = r % BW;
         if (m_byp) begin
            e_win = 1; e_cx = c; e_cy = r;
         end else if (r >= BW - 1 && c >= BW - 1) begin
            e_win = 1; e_cx = c - HALF; e_cy = r - HALF;
         end
         m_n++;
         if (m_n == H * V) begin
            m_act = 0; m_pend = 1;
         end
      end
   endtask

   task automatic check_all();
      chk("wr_en",   32'(bus.o_wr_en),      e_wr);
      chk("addr",    32'(bus.o_addr),       e_addr);
      chk("wr_bank", 32'(bus.o_wr_bank),    e_bank);
      chk("top",     32'(bus.o_top_bank),   (e_bank + 1) % BW);
      chk("win",     32'(bus.o_win_valid),  e_win);
      chk("ctr_x",   32'(bus.o_ctr_x),      e_cx);
      chk("ctr_y",   32'(bus.o_ctr_y),      e_cy);
      chk("bypass",  32'(bus.o_bypass),     32'(m_byp));
      chk("done",    32'(bus.o_frame_done), e_done);
   endtask

   task automatic clear_obs();
      wcnt = 0; last_wr = -1; done_cyc = -1; dcnt = 0; ridx = 0;
      fx = -1; fy = -1; lx = -1; ly = -1;
      for (int i = 0; i < 6; i++) banks[i] = -1;
   endtask

   task automatic step(bit fs, bit pv, bit byp);
      bus.i_frame_start = fs;
      bus.i_pix_valid   = pv;
      bus.i_bypass      = byp;
      model(fs, pv, byp);
      @(posedge clk); #1;
      cyc++;
      check_all();
      if (bus.o_win_valid) begin
         if (wcnt == 0) begin
            fx = int'(bus.o_ctr_x); fy = int'(bus.o_ctr_y);
         end
         lx = int'(bus.o_ctr_x); ly = int'(bus.o_ctr_y);
         wcnt++;
      end
      if (bus.o_wr_en) begin
         last_wr = cyc;
         if (bus.o_addr == 0 && ridx < 6) begin
            banks[ridx] = int'(bus.o_wr_bank);
            ridx++;
         end
      end
      if (bus.o_frame_done) begin
         done_cyc = cyc; dcnt++;
      end
   endtask

   task automatic check_frame(string tag);
      chk({tag, "_wcnt"}, wcnt, 8);
      chk({tag, "_fx"}, fx, 2);
      chk({tag, "_fy"}, fy, 2);
      chk({tag, "_lx"}, lx, 5);
      chk({tag, "_ly"}, ly, 3);
      chk({tag, "_dcnt"}, dcnt, 1);
      chk({tag, "_dlat"}, done_cyc - last_wr, 1);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int fed, guard;
      tbl[0] = '{0, 1, 0, 0, 0, 0, 0, 0};
      tbl[1] = '{1, 0, 0, 0, 0, 0, 0, 0};
      tbl[2] = '{0, 1, 0, 1, 0, 0, 0, 0};
      tbl[3] = '{0, 1, 0, 1, 1, 0, 0, 0};
      tbl[4] = '{0, 0, 0, 0, 1, 0, 0, 0};
      tbl[5] = '{0, 1, 0, 1, 2, 0, 0, 0};
      tbl[6] = '{1, 1, 1, 1, 0, 0, 1, 1};
      tbl[7] = '{0, 1, 0, 1, 1, 0, 1, 1};

      cyc = 0;
      clear_obs();
      model_reset();
      bus.i_frame_start = 0;
      bus.i_pix_valid   = 0;
      bus.i_bypass      = 0;
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;

      // table-driven vectors from idle
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].fs, tbl[i].pv, tbl[i].byp);
         chk("tbl_wr",   32'(bus.o_wr_en),     tbl[i].wr);
         chk("tbl_addr", 32'(bus.o_addr),      tbl[i].addr);
         chk("tbl_bank", 32'(bus.o_wr_bank),   tbl[i].bank);
         chk("tbl_win",  32'(bus.o_win_valid), tbl[i].win);
         chk("tbl_byp",  32'(bus.o_bypass),    tbl[i].bypass);
      end

      // test 1: asynchronous reset mid-stream
      for (int i = 0; i < 10; i++) step(0, 1, 0);
      #1 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("rst_top", 32'(bus.o_top_bank), 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step(0, 1, 0);
      chk("rst_wr", 32'(bus.o_wr_en), 0);

      // tests 2,3: full back-to-back frame
      clear_obs();
      step(1, 0, 0);
      for (int i = 0; i < H * V; i++) step(0, 1, 0);
      idle(4);
      check_frame("t2");
      for (int r = 0; r < 6; r++)
         chk("t3_bank", banks[r], r % BW);

      // test 4: random gaps
      clear_obs();
      step(1, 0, 0);
      fed = 0;
      guard = 0;
      while (fed < H * V && guard < 1000) begin
         bit pv;
         pv = ($urandom_range(0, 2) != 0);
         step(0, pv, 0);
         if (pv) fed++;
         guard++;
      end
      chk("t4_fed", fed, H * V);
      idle(4);
      check_frame("t4");

      // test 5: restart mid-frame at row 3, col 5
      clear_obs();
      step(1, 0, 0);
      for (int i = 0; i < 3 * H + 5; i++) step(0, 1, 0);
      step(1, 1, 0);
      chk("t5_addr", 32'(bus.o_addr), 0);
      chk("t5_bank", 32'(bus.o_wr_bank), 0);
      chk("t5_wr", 32'(bus.o_wr_en), 1);
      chk("t5_nodone", dcnt, 0);
      clear_obs();
      for (int i = 1; i < H * V; i++) step(0, 1, 0);
      idle(4);
      check_frame("t5");

      // test 6: bypass latched at frame start
      clear_obs();
      step(1, 0, 1);
      for (int i = 0; i < H * V; i++)
         step(0, 1, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 3; i++) step(0, 1, 0);
      idle(2);
      chk("t6_wcnt", wcnt, H * V);
      chk("t6_lx", lx, H - 1);
      chk("t6_ly", ly, V - 1);
      chk("t6_dcnt", dcnt, 1);
      chk("t6_byp", 32'(bus.o_bypass), 1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
